// File: rtl/cop2_pkg.sv
// Shared constants and helpers for the COP2 endpoint in the vector unit.
package cop2_pkg;

  localparam int COP2_WIDTH     = 32;
  localparam int COP2_IN_DEPTH  = 4;
  localparam int COP2_OUT_DEPTH = 4;

  // Bit positions inside err_sticky (status build only).
  localparam int ERR_CMD_EMPTY = 0;
  localparam int ERR_RES_FULL  = 1;

  // Ceiling log2, usable in constant expressions; returns 0 for n <= 1.
  function automatic int log2c(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cop2_ep_fifo.sv
// Synchronous FIFO with pre-qualified push/pop strobes, registered occupancy
// count and a head that reads zero whenever the FIFO is empty.
module cop2_ep_fifo
  import cop2_pkg::*;
#(
  parameter int WIDTH = COP2_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        head,
  output logic [log2c(DEPTH):0]   count
);

  localparam int AW = log2c(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Caller guarantees push only when not full, or when a pop frees the slot
  // in the same cycle; pop only when not empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the zero count alone makes old
  // contents unreachable, and the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/cop2_ep.sv
// COP2 endpoint: inbound CPU->vector FIFO and outbound vector->CPU FIFO.
// Optional status outputs (levels, sticky errors) under COP2_EP_STATUS_EN.
module cop2_ep
  import cop2_pkg::*;
#(
  parameter int WIDTH     = COP2_WIDTH,
  parameter int IN_DEPTH  = COP2_IN_DEPTH,
  parameter int OUT_DEPTH = COP2_OUT_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             tocop2,
  input  logic                         tocop2_en,
  output logic                         tocop2_wait,
  output logic [WIDTH-1:0]             fromcop2,
  output logic                         fromcop2_en,
  input  logic                         fromcop2_wait,
  output logic [WIDTH-1:0]             cmd_data,
  output logic                         cmd_valid,
  input  logic                         cmd_rd,
  input  logic [WIDTH-1:0]             res_data,
  input  logic                         res_wr,
  output logic                         res_full
`ifdef COP2_EP_STATUS_EN
  ,
  output logic [log2c(IN_DEPTH):0]     in_level,
  output logic [log2c(OUT_DEPTH):0]    out_level,
  output logic [1:0]                   err_sticky
`endif
);

  localparam int ICW = log2c(IN_DEPTH) + 1;
  localparam int OCW = log2c(OUT_DEPTH) + 1;

  logic [ICW-1:0] in_count;
  logic [OCW-1:0] out_count;
  logic in_full, in_empty, in_push, in_pop;
  logic out_full, out_empty, out_push, out_pop;

  assign in_full   = (in_count == ICW'(IN_DEPTH));
  assign in_empty  = (in_count == '0);
  assign out_full  = (out_count == OCW'(OUT_DEPTH));
  assign out_empty = (out_count == '0);

  // Wait comes only from the registered count, so a same-cycle pop while
  // full still stalls the CPU for one bubble.
  assign tocop2_wait = in_full;
  assign in_push     = tocop2_en & ~in_full;
  assign in_pop      = cmd_rd & ~in_empty;
  assign cmd_valid   = ~in_empty;

  // Outbound may take a write while full when the CPU drains the head in
  // the same cycle; otherwise a write at full is dropped.
  assign fromcop2_en = ~out_empty;
  assign out_pop     = ~out_empty & ~fromcop2_wait;
  assign out_push    = res_wr & (~out_full | out_pop);
  assign res_full    = out_full;

  cop2_ep_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (IN_DEPTH)
  ) u_in_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_push),
    .pop   (in_pop),
    .wdata (tocop2),
    .head  (cmd_data),
    .count (in_count)
  );

  cop2_ep_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (out_push),
    .pop   (out_pop),
    .wdata (res_data),
    .head  (fromcop2),
    .count (out_count)
  );

`ifdef COP2_EP_STATUS_EN
  assign in_level  = in_count;
  assign out_level = out_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_sticky <= '0;
    end else begin
      if (cmd_rd & in_empty)             err_sticky[ERR_CMD_EMPTY] <= 1'b1;
      if (res_wr & out_full & ~out_pop)  err_sticky[ERR_RES_FULL]  <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cop2_ep.sv
// Scoreboard bench for cop2_ep: directed scenarios followed by random traffic.
// Status outputs are checked when COP2_EP_STATUS_EN is defined.
module tb_cop2_ep;
  import cop2_pkg::*;

  localparam int W  = 32;
  localparam int ID = 4;
  localparam int OD = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] tocop2;
  logic         tocop2_en;
  logic         tocop2_wait;
  logic [W-1:0] fromcop2;
  logic         fromcop2_en;
  logic         fromcop2_wait;
  logic [W-1:0] cmd_data;
  logic         cmd_valid;
  logic         cmd_rd;
  logic [W-1:0] res_data;
  logic         res_wr;
  logic         res_full;
`ifdef COP2_EP_STATUS_EN
  logic [2:0]   in_level;
  logic [2:0]   out_level;
  logic [1:0]   err_sticky;
`endif

  always #5 clk = ~clk;

  cop2_ep #(.WIDTH(W), .IN_DEPTH(ID), .OUT_DEPTH(OD)) dut (
    .clk           (clk),
    .reset         (reset),
    .tocop2        (tocop2),
    .tocop2_en     (tocop2_en),
    .tocop2_wait   (tocop2_wait),
    .fromcop2      (fromcop2),
    .fromcop2_en   (fromcop2_en),
    .fromcop2_wait (fromcop2_wait),
    .cmd_data      (cmd_data),
    .cmd_valid     (cmd_valid),
    .cmd_rd        (cmd_rd),
    .res_data      (res_data),
    .res_wr        (res_wr),
    .res_full      (res_full)
`ifdef COP2_EP_STATUS_EN
    ,
    .in_level      (in_level),
    .out_level     (out_level),
    .err_sticky    (err_sticky)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected contents of each FIFO as plain queues.
  logic [W-1:0] exp_in[$];
  logic [W-1:0] exp_out[$];
  bit           in_popped, out_popped;
  bit           in_acc, out_acc;
  logic [1:0]   err_m;
  int           in_occ, out_occ;

  // Stimulus side: on each edge decide acceptance and enqueue expectations.
  always @(posedge clk) begin
    if (reset) begin
      exp_in.delete();
      exp_out.delete();
      err_m   = 2'b00;
      in_acc  = 1'b0;
      out_acc = 1'b0;
    end else begin
      in_occ  = exp_in.size() + int'(in_popped);
      out_occ = exp_out.size() + int'(out_popped);
      in_acc  = tocop2_en && (in_occ < ID);
      if (in_acc) exp_in.push_back(tocop2);
      if (cmd_rd && in_occ == 0) err_m[0] = 1'b1;
      out_acc = res_wr && ((out_occ < OD) || out_popped);
      if (res_wr && !out_acc) err_m[1] = 1'b1;
      if (out_acc) exp_out.push_back(res_data);
    end
  end

  // Monitor: compare flags and heads, pop expectations as words are consumed.
  always @(negedge clk) begin
    check("tocop2_wait", tocop2_wait, exp_in.size() == ID);
    check("cmd_valid", cmd_valid, exp_in.size() != 0);
    check("fromcop2_en", fromcop2_en, exp_out.size() != 0);
    check("res_full", res_full, exp_out.size() == OD);
`ifdef COP2_EP_STATUS_EN
    check("in_level", in_level, exp_in.size());
    check("out_level", out_level, exp_out.size());
    check("err_sticky", err_sticky, err_m);
`endif
    in_popped  = 1'b0;
    out_popped = 1'b0;
    if (exp_in.size() != 0) begin
      check("cmd_data", cmd_data, exp_in[0]);
      if (!reset && cmd_rd) begin
        void'(exp_in.pop_front());
        in_popped = 1'b1;
      end
    end else begin
      check("cmd_data_empty", cmd_data, 0);
    end
    if (exp_out.size() != 0) begin
      check("fromcop2", fromcop2, exp_out[0]);
      if (!reset && !fromcop2_wait) begin
        void'(exp_out.pop_front());
        out_popped = 1'b1;
      end
    end else begin
      check("fromcop2_empty", fromcop2, 0);
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    tocop2_en     = 1'b0;
    cmd_rd        = 1'b0;
    res_wr        = 1'b0;
    fromcop2_wait = 1'b1;
  endtask

  // Present a word and hold it until the model says it was taken.
  task automatic cpu_push(input logic [W-1:0] d);
    tocop2    = d;
    tocop2_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (in_acc) break;
    end
    tocop2_en = 1'b0;
  endtask

  task automatic core_push(input logic [W-1:0] d);
    res_data = d;
    res_wr   = 1'b1;
    step();
    res_wr   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    tocop2 = '0;
    res_data = '0;
    idle();
    step(2);
    reset = 1'b0;
    step();

    // Ordered inbound traffic and one-cycle visibility.
    cpu_push(32'h11);
    cpu_push(32'h22);
    cpu_push(32'h33);
    step();
    cmd_rd = 1'b1;
    step(4);
    cmd_rd = 1'b0;

    // Fill inbound, hold a fifth word, free one slot.
    for (int i = 1; i <= 4; i++) cpu_push(32'hA0 + i);
    tocop2    = 32'hA5;
    tocop2_en = 1'b1;
    step(2);
    cmd_rd = 1'b1;
    step();
    cmd_rd = 1'b0;
    for (int i = 0; i < 4 && !in_acc; i++) step();
    tocop2_en = 1'b0;
    cmd_rd = 1'b1;
    step(6);
    cmd_rd = 1'b0;

    // Outbound head stable under wait, then drained.
    core_push(32'hA);
    core_push(32'hB);
    step(3);
    fromcop2_wait = 1'b0;
    step(3);
    fromcop2_wait = 1'b1;

    // Outbound full with simultaneous drain and append.
    for (int i = 0; i < 4; i++) core_push(32'h100 + i);
    res_data      = 32'h1FF;
    res_wr        = 1'b1;
    fromcop2_wait = 1'b0;
    step();
    res_wr = 1'b0;
    step(6);
    fromcop2_wait = 1'b1;

    // Reset with both FIFOs partly occupied.
    cpu_push(32'h66);
    cpu_push(32'h77);
    core_push(32'h88);
    core_push(32'h99);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    cpu_push(32'h55);
    cmd_rd = 1'b1;
    step(2);
    cmd_rd = 1'b0;

    // Protocol errors: read while empty, write while full and stalled.
    cmd_rd = 1'b1;
    step();
    cmd_rd = 1'b0;
    for (int i = 0; i < 5; i++) core_push(32'h200 + i);
    step(2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    // Random traffic with varying pressure on each side.
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 600; c++) begin
        reset         = ($urandom_range(0, 299) == 0);
        tocop2        = $urandom;
        tocop2_en     = ($urandom_range(0, 3) < 1 + ph % 3);
        cmd_rd        = ($urandom_range(0, 3) < 3 - ph % 3);
        res_data      = $urandom;
        res_wr        = ($urandom_range(0, 3) < 1 + ph);
        fromcop2_wait = ($urandom_range(0, 3) < ph);
        step();
      end
    end

    reset = 1'b0;
    tocop2_en = 1'b0;
    res_wr = 1'b0;
    cmd_rd = 1'b1;
    fromcop2_wait = 1'b0;
    step(8);
    idle();
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
